// File: rtl/uncache_store_buffer_pkg.sv
// Shared definitions for the uncached store buffer: AXI constants, drain FSM
// states and the address alignment helper.
package uncache_store_buffer_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   typedef enum logic [1:0] {
      DRAIN_IDLE = 2'd0,
      DRAIN_SEND = 2'd1,
      DRAIN_RESP = 2'd2
   } drain_state_e;

   // Low address bits kept for an access of the given size (byte keeps both).
   function automatic logic [1:0] size_low_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 2'b11;
         2'd1:    return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/uncache_store_buffer_sb_fifo_mem.sv
// In-order entry storage for the uncached store buffer, with a per-entry
// word-address compare against the load probe.
module uncache_store_buffer_sb_fifo_mem #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                push,
   input  logic [ADDR_W-1:0]   push_addr,
   input  logic [1:0]          push_size,
   input  logic [DATA_W-1:0]   push_wdata,
   input  logic [DATA_W/8-1:0] push_wstrb,
   input  logic                pop,
   input  logic [ADDR_W-3:0]   chk_word,
   output logic [ADDR_W-1:0]   head_addr,
   output logic [1:0]          head_size,
   output logic [DATA_W-1:0]   head_wdata,
   output logic [DATA_W/8-1:0] head_wstrb,
   output logic [CNT_W-1:0]    count,
   output logic [DEPTH-1:0]    hit_vec
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [1:0]          size;
      logic [DATA_W-1:0]   wdata;
      logic [DATA_W/8-1:0] wstrb;
   } sb_entry_t;

   sb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= {push_addr, push_size, push_wdata, push_wstrb};
      end
   end

   assign head_addr  = mem[head].addr;
   assign head_size  = mem[head].size;
   assign head_wdata = mem[head].wdata;
   assign head_wstrb = mem[head].wstrb;

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = valid[i] && (mem[i].addr[ADDR_W-1:2] == chk_word);
      end
   end

endmodule

// File: rtl/uncache_store_buffer.sv
// Posted-write buffer for uncached stores: stores retire on enqueue and drain
// in order as single-beat AXI writes, one outstanding at a time.
//
// state      | meaning
// DRAIN_IDLE | no write in flight; latch head entry onto AXI regs if any
// DRAIN_SEND | AW and W offered; each channel drops after its own handshake
// DRAIN_RESP | both beats accepted; waiting for B, then retire the head
module uncache_store_buffer
   import uncache_store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int AXI_ID = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         st_valid,
   output logic                         st_ready,
   input  logic [ADDR_W-1:0]            st_addr,
   input  logic [1:0]                   st_size,
   input  logic [DATA_W-1:0]            st_wdata,
   input  logic [DATA_W/8-1:0]          st_wstrb,
   input  logic                         ld_chk_valid,
   input  logic [ADDR_W-1:0]            ld_chk_addr,
   output logic                         ld_conflict,
   output logic                         sb_empty,
   output logic [$clog2(DEPTH+1)-1:0]   sb_count,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [ADDR_W-1:0]            awaddr,
   output logic [2:0]                   awsize,
   output logic [7:0]                   awlen,
   output logic [1:0]                   awburst,
   output logic [3:0]                   awid,
   output logic                         wvalid,
   input  logic                         wready,
   output logic [DATA_W-1:0]            wdata,
   output logic [DATA_W/8-1:0]          wstrb,
   output logic                         wlast,
   input  logic                         bvalid,
   output logic                         bready,
   input  logic [1:0]                   bresp
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   drain_state_e        state;
   drain_state_e        state_nxt;
   logic                aw_done;
   logic                w_done;
   logic                aw_hs;
   logic                w_hs;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    count;
   logic [DEPTH-1:0]    hit_vec;
   logic [ADDR_W-1:0]   head_addr;
   logic [1:0]          head_size;
   logic [DATA_W-1:0]   head_wdata;
   logic [DATA_W/8-1:0] head_wstrb;
   logic                unused_ok;

   assign st_ready = (count != CNT_W'(DEPTH));
   assign push     = st_valid && st_ready;
   assign sb_empty = (count == '0);
   assign sb_count = count;

   uncache_store_buffer_sb_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (push),
      .push_addr  (st_addr),
      .push_size  (st_size),
      .push_wdata (st_wdata),
      .push_wstrb (st_wstrb),
      .pop        (pop),
      .chk_word   (ld_chk_addr[ADDR_W-1:2]),
      .head_addr  (head_addr),
      .head_size  (head_size),
      .head_wdata (head_wdata),
      .head_wstrb (head_wstrb),
      .count      (count),
      .hit_vec    (hit_vec)
   );

   assign ld_conflict = ld_chk_valid && (|hit_vec);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= DRAIN_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      awvalid   = (state == DRAIN_SEND) && !aw_done;
      wvalid    = (state == DRAIN_SEND) && !w_done;
      bready    = (state == DRAIN_RESP);
      aw_hs     = awvalid && awready;
      w_hs      = wvalid && wready;
      case (state)
         DRAIN_IDLE: if (count != '0) state_nxt = DRAIN_SEND;
         DRAIN_SEND: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = DRAIN_RESP;
         DRAIN_RESP: begin
            // Response code is not propagated; the entry retires either way.
            if (bvalid) begin
               pop       = 1'b1;
               state_nxt = DRAIN_IDLE;
            end
         end
         default: state_nxt = DRAIN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awaddr  <= '0;
         awsize  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else if (state == DRAIN_IDLE) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         if (count != '0) begin
            awaddr <= {head_addr[ADDR_W-1:2], head_addr[1:0] & size_low_mask(head_size)};
            awsize <= {1'b0, head_size};
            wdata  <= head_wdata;
            wstrb  <= head_wstrb;
         end
      end else if (state == DRAIN_SEND) begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

   assign awlen   = AXI_LEN_SINGLE;
   assign awburst = AXI_BURST_INCR;
   assign awid    = 4'(AXI_ID);
   assign wlast   = 1'b1;

   assign unused_ok = ^{bresp, ld_chk_addr[1:0]};

endmodule

// File: tb/tb_uncache_store_buffer.sv
// Bench for uncache_store_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uncache_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        st_valid, st_ready;
   logic [31:0] st_addr;
   logic [1:0]  st_size;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        ld_chk_valid, ld_conflict;
   logic [31:0] ld_chk_addr;
   logic        sb_empty;
   logic [2:0]  sb_count;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic [3:0]  awid;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;

   always #5 clk = ~clk;

   uncache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .AXI_ID(1)) dut (
      .clk (clk), .resetn (resetn),
      .st_valid (st_valid), .st_ready (st_ready), .st_addr (st_addr), .st_size (st_size),
      .st_wdata (st_wdata), .st_wstrb (st_wstrb),
      .ld_chk_valid (ld_chk_valid), .ld_chk_addr (ld_chk_addr), .ld_conflict (ld_conflict),
      .sb_empty (sb_empty), .sb_count (sb_count),
      .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awsize (awsize),
      .awlen (awlen), .awburst (awburst), .awid (awid),
      .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
      .bvalid (bvalid), .bready (bready), .bresp (bresp)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
      logic [3:0]  strb;
   } ent_t;

   ent_t        q[$];
   bit          active, aw_seen, w_seen;
   logic [31:0] aw_log[$];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] s);
      return a & ~((32'd1 << s) - 32'd1);
   endfunction

   function automatic bit probe_hit(input logic [31:0] p);
      foreach (q[i]) if (q[i].addr[31:2] == p[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: drive, compare against the model, then advance the model
   // to what must hold after the coming edge.
   task automatic step(input bit sv, input logic [31:0] sa, input logic [1:0] ss,
                       input logic [31:0] sd, input logic [3:0] sw,
                       input bit pv, input logic [31:0] pa,
                       input bit awr, input bit wr, input bit bv);
      bit   exp_aw, exp_w, exp_b, push, aw_hs, w_hs, b_hs, start;
      ent_t e;
      @(negedge clk);
      st_valid = sv; st_addr = sa; st_size = ss; st_wdata = sd; st_wstrb = sw;
      ld_chk_valid = pv; ld_chk_addr = pa;
      awready = awr; wready = wr;
      bvalid = bv && active && aw_seen && w_seen;
      bresp = 2'($urandom);
      #1;
      exp_aw = active && !aw_seen;
      exp_w  = active && !w_seen;
      exp_b  = active && aw_seen && w_seen;
      chk("sb_count", sb_count, q.size());
      chk("sb_empty", sb_empty, q.size() == 0);
      chk("st_ready", st_ready, q.size() != DEPTH);
      chk("ld_conflict", ld_conflict, pv && probe_hit(pa));
      chk("awvalid", awvalid, exp_aw);
      chk("wvalid", wvalid, exp_w);
      chk("bready", bready, exp_b);
      push  = sv && (q.size() != DEPTH);
      aw_hs = exp_aw && awr;
      w_hs  = exp_w && wr;
      b_hs  = exp_b && bvalid;
      if (aw_hs) begin
         chk("awaddr", awaddr, align(q[0].addr, q[0].size));
         chk("awsize", awsize, {1'b0, q[0].size});
         chk("awlen", awlen, 0);
         chk("awburst", awburst, 1);
         chk("awid", awid, 1);
         aw_log.push_back(awaddr);
      end
      if (w_hs) begin
         chk("wdata", wdata, q[0].data);
         chk("wstrb", wstrb, q[0].strb);
         chk("wlast", wlast, 1);
      end
      start = !active && (q.size() != 0);
      if (aw_hs) aw_seen = 1'b1;
      if (w_hs)  w_seen  = 1'b1;
      if (b_hs) begin
         void'(q.pop_front());
         active = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
      end
      if (start) active = 1'b1;
      if (push) begin
         e.addr = sa; e.size = ss; e.data = sd; e.strb = sw;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n, input bit awr, input bit wr, input bit bv);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, awr, wr, bv);
   endtask

   task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] w, input bit awr, input bit wr);
      step(1, a, s, d, w, 0, 0, awr, wr, 0);
   endtask

   task automatic probe(input logic [31:0] a);
      step(0, 0, 0, 0, 0, 1, a, 0, 0, 0);
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && (q.size() != 0 || active); i++)
         step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
   endtask

   initial begin
      logic [31:0] exp_order [4];
      logic [31:0] ra;
      logic [1:0]  rs;

      st_valid = 0; st_addr = 0; st_size = 0; st_wdata = 0; st_wstrb = 0;
      ld_chk_valid = 0; ld_chk_addr = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_empty", sb_empty, 1);
      @(negedge clk); resetn = 1'b1;
      step(0, 0, 0, 0, 0, 1, 32'h1FAF_F010, 1, 1, 0);
      chk("rst_count", sb_count, 0);
      chk("rst_st_ready", st_ready, 1);
      chk("rst_ld_conflict", ld_conflict, 0);

      // Single store
      aw_log.delete();
      store(32'h1FAF_F010, 2, 32'hDEAD_BEEF, 4'hF, 1, 1);
      idle(4, 1, 1, 0);
      drain(20);
      chk("single_aw_count", aw_log.size(), 1);
      chk("single_awaddr", aw_log[0], 32'h1FAF_F010);
      idle(1, 1, 1, 0);
      chk("single_empty", sb_empty, 1);

      // Fill with AXI stalled, then release
      aw_log.delete();
      for (int i = 0; i < 4; i++) store(32'h1FD0_0100 + 32'(i * 4), 2, 32'h1000 + 32'(i), 4'hF, 0, 0);
      idle(1, 0, 0, 0);
      chk("fill_count", sb_count, 4);
      chk("fill_st_ready", st_ready, 0);
      drain(60);
      exp_order = '{32'h1FD0_0100, 32'h1FD0_0104, 32'h1FD0_0108, 32'h1FD0_010C};
      chk("fill_aw_count", aw_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("fill_order", aw_log[i], exp_order[i]);

      // Split handshake: W first, then AW
      aw_log.delete();
      store(32'h1FD0_0200, 2, 32'h5555_AAAA, 4'hF, 0, 1);
      idle(6, 0, 1, 0);
      chk("split_aw_hold", awvalid, 1);
      chk("split_w_done", wvalid, 0);
      chk("split_no_bready", bready, 0);
      drain(20);
      // Split handshake: AW first, then W
      store(32'h1FD0_0204, 1, 32'h1234_0000, 4'hC, 1, 0);
      idle(6, 1, 0, 0);
      chk("split2_w_hold", wvalid, 1);
      chk("split2_no_bready", bready, 0);
      drain(20);
      chk("split_aw_count", aw_log.size(), 2);

      // Load conflict against a buffered byte store
      store(32'h1FD0_0003, 0, 32'hAB00_0000, 4'h8, 0, 0);
      idle(2, 0, 0, 0);
      probe(32'h1FD0_0000);
      chk("conflict_hit", ld_conflict, 1);
      probe(32'h1FD0_0004);
      chk("conflict_miss", ld_conflict, 0);
      drain(20);
      probe(32'h1FD0_0000);
      chk("conflict_retired", ld_conflict, 0);

      // Push and pop together across the pointer wrap
      for (int i = 0; i < 2; i++) begin
         store(32'h1FD0_0300 + 32'(i * 4), 2, 32'(i), 4'hF, 1, 1);
         drain(20);
      end
      aw_log.delete();
      store(32'h1FD0_0400, 2, 32'hA, 4'hF, 0, 0);
      store(32'h1FD0_0404, 2, 32'hB, 4'hF, 0, 0);
      for (int i = 0; i < 20 && !(active && aw_seen && w_seen); i++) idle(1, 1, 1, 0);
      step(1, 32'h1FD0_0408, 2, 32'hC, 4'hF, 0, 0, 1, 1, 1);
      idle(1, 0, 0, 0);
      chk("pushpop_count", sb_count, 2);
      drain(40);
      chk("pushpop_aw_count", aw_log.size(), 3);
      chk("pushpop_wrap_order", aw_log[2], 32'h1FD0_0408);

      // Asynchronous reset while a write is being offered
      for (int i = 0; i < 3; i++) store(32'h1FD0_0500 + 32'(i * 4), 2, 32'(i), 4'hF, 0, 0);
      idle(1, 0, 0, 0);
      chk("pre_rst_awvalid", awvalid, 1);
      resetn = 1'b0;
      #1;
      chk("async_rst_awvalid", awvalid, 0);
      chk("async_rst_wvalid", wvalid, 0);
      chk("async_rst_count", sb_count, 0);
      chk("async_rst_empty", sb_empty, 1);
      q.delete(); active = 0; aw_seen = 0; w_seen = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      aw_log.delete();
      idle(10, 1, 1, 1);
      chk("post_rst_writes", aw_log.size(), 0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         rs = 2'($urandom_range(0, 2));
         ra = 32'h1FD0_0000 | (32'($urandom_range(0, 7)) << 2);
         ra = ra | align(32'($urandom_range(0, 3)), rs);
         step($urandom_range(0, 1) == 1, ra, rs, $urandom, 4'($urandom),
              $urandom_range(0, 1) == 1, 32'h1FD0_0000 | (32'($urandom_range(0, 9)) << 2),
              $urandom_range(0, 4) > 1, $urandom_range(0, 4) > 1, $urandom_range(0, 1) == 1);
      end
      drain(100);
      idle(1, 1, 1, 0);
      chk("final_empty", sb_empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
